// File: rtl/mul_div_unit_pkg.sv
// Shared MDU definitions: operation encodings, result bundle, behavioural datapath.
// Latency: n/a (pure types and a combinational helper).
// Backpressure: n/a.
package mul_div_unit_pkg;

  // MDUOP encodings, kept alongside the ALUOP constants in the execute stage.
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } mduop_e;

  localparam int MD_CNT_W = 8;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        divz;  // divide by zero: commit must leave HI/LO alone
  } md_res_t;

  function automatic logic is_muldiv(input mduop_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(input mduop_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Whole result in one cycle; the counter in the top only models latency.
  function automatic md_res_t md_compute(input mduop_e op, input logic [31:0] a,
                                         input logic [31:0] b);
    md_res_t             r;
    logic signed [63:0]  sp;
    logic        [63:0]  up;
    logic signed [31:0]  sa;
    logic signed [31:0]  sb;
    r  = '0;
    sa = a;
    sb = b;
    sp = '0;
    up = '0;
    case (op)
      MD_MULT: begin
        sp   = {{32{a[31]}}, a};
        sp   = sp * $signed({{32{b[31]}}, b});
        r.hi = sp[63:32];
        r.lo = sp[31:0];
      end
      MD_MULTU: begin
        up   = {32'd0, a} * {32'd0, b};
        r.hi = up[63:32];
        r.lo = up[31:0];
      end
      MD_DIV: begin
        if (b == 32'd0) begin
          r.divz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          // Only signed overflow case; pinned explicitly rather than left to '/'.
          r.lo = 32'h8000_0000;
          r.hi = 32'd0;
        end else begin
          r.lo = sa / sb;  // truncates toward zero
          r.hi = sa % sb;  // takes the sign of the dividend
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) begin
          r.divz = 1'b1;
        end else begin
          r.lo = a / b;
          r.hi = a % b;
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// MDU execute-stage bundle: op/launch/operands in, busy/HI/LO/read-mux out.
// Latency: n/a (wires only).
// Backpressure: none here; busy is consumed by the hazard unit to stall D.
interface mul_div_unit_if;
  import mul_div_unit_pkg::*;

  mduop_e      mduop;   // operation code
  logic        start;   // 1-cycle launch qualifier for mul/div
  logic [31:0] srca;    // rs operand (forwarded)
  logic [31:0] srcb;    // rt operand (forwarded)
  logic        busy;    // high while a mul/div is in flight
  logic [31:0] hi;      // registered HI
  logic [31:0] lo;      // registered LO
  logic [31:0] mduout;  // MFHI/MFLO read value

  modport master (output mduop, start, srca, srcb,
                  input  busy, hi, lo, mduout);
  modport slave  (input  mduop, start, srca, srcb,
                  output busy, hi, lo, mduout);
endinterface

// File: rtl/mul_div_unit.sv
// Multiply/divide unit owning HI/LO; MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
// Latency: mul busy MUL_CYCLES, div busy DIV_CYCLES; MTHI/MTLO 1 cycle; MFHI/MFLO comb.
// Backpressure: start while busy is dropped; upstream must stall on busy.
// Ports: clk, reset (sync active-high), md (slave side of mul_div_unit_if).
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave md
);

  logic                busy_q;
  logic [MD_CNT_W-1:0] cnt_q;
  logic [31:0]         hi_q;
  logic [31:0]         lo_q;
  logic [31:0]         hi_nxt;
  logic [31:0]         lo_nxt;
  logic                divz_q;

  logic    launch;
  md_res_t launch_res;

  always_comb begin
    launch     = md.start && !busy_q && is_muldiv(md.mduop);
    launch_res = md_compute(md.mduop, md.srca, md.srcb);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Also drops any pending result, so an aborted op can never commit.
      busy_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      hi_nxt <= '0;
      lo_nxt <= '0;
      divz_q <= 1'b0;
    end else if (busy_q) begin
      // cnt==1 here means it reaches 0 on this edge: commit and release together.
      if (cnt_q == MD_CNT_W'(1)) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
        if (!divz_q) begin
          hi_q <= hi_nxt;
          lo_q <= lo_nxt;
        end
      end else begin
        cnt_q <= cnt_q - MD_CNT_W'(1);
      end
    end else if (launch) begin
      hi_nxt <= launch_res.hi;
      lo_nxt <= launch_res.lo;
      divz_q <= launch_res.divz;
      cnt_q  <= is_div(md.mduop) ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MUL_CYCLES);
      busy_q <= 1'b1;
    end else if (md.mduop == MD_MTHI) begin
      hi_q <= md.srca;
    end else if (md.mduop == MD_MTLO) begin
      lo_q <= md.srca;
    end
  end

  assign md.busy   = busy_q;
  assign md.hi     = hi_q;
  assign md.lo     = lo_q;
  assign md.mduout = (md.mduop == MD_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with an expected-result queue.
// Latency: checks busy duration per op, then HI/LO after commit.
// Backpressure: exercises start-while-busy and reset-while-busy.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   passed = 0;
  int   failed = 0;
  logic [63:0] exp_q[$];

  mul_div_unit_if mif ();

  mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mif.start = 1'b0;
    mif.mduop = MD_NONE;
  endtask

  // Launch one mul/div, count busy cycles (optionally injecting a second
  // start+MULT at busy cycle inj), then compare against the queued result.
  task automatic run_op(input string tag, input mduop_e op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input int inj,
                        input logic [31:0] eh, input logic [31:0] el);
    int          cnt;
    logic [63:0] e;
    exp_q.push_back({eh, el});
    @(negedge clk);
    mif.mduop = op;
    mif.start = 1'b1;
    mif.srca  = a;
    mif.srcb  = b;
    @(negedge clk);
    idle_inputs();
    cnt = 0;
    while (mif.busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == inj) begin
        mif.start = 1'b1;
        mif.mduop = MD_MULT;
        mif.srca  = 32'd5;
        mif.srcb  = 32'd5;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
    end
    idle_inputs();
    check({tag, "_busy_cycles"}, 32'(cnt), 32'(n));
    e = exp_q.pop_front();
    check({tag, "_hi"}, mif.hi, e[63:32]);
    check({tag, "_lo"}, mif.lo, e[31:0]);
  endtask

  initial begin
    reset    = 1'b1;
    mif.srca = '0;
    mif.srcb = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 32'(mif.busy), 32'd0);
    check("reset_hi", mif.hi, 32'd0);
    check("reset_lo", mif.lo, 32'd0);

    // Signed multiply, then both read-mux selections.
    run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    mif.mduop = MD_MFLO;
    #1 check("mflo_after_mult", mif.mduout, 32'hFFFF_FFFA);
    mif.mduop = MD_MFHI;
    #1 check("mfhi_after_mult", mif.mduout, 32'hFFFF_FFFF);
    idle_inputs();

    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", MD_DIVU, 32'hFFFF_FFF9, 32'd2, 10, 0, 32'h0000_0001, 32'h7FFF_FFFC);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 0, 32'h0000_0000, 32'h8000_0000);

    // MTHI then MFHI; busy must stay low.
    @(negedge clk);
    mif.mduop = MD_MTHI;
    mif.srca  = 32'h1234_5678;
    @(negedge clk);
    mif.mduop = MD_MFHI;
    #1 check("mthi_mfhi", mif.mduout, 32'h1234_5678);
    check("mthi_busy", 32'(mif.busy), 32'd0);
    idle_inputs();

    // Divide by zero: full latency, HI/LO untouched.
    run_op("div_by0", MD_DIV, 32'd77, 32'd0, 10, 0, 32'h1234_5678, 32'h8000_0000);

    // MTLO path.
    @(negedge clk);
    mif.mduop = MD_MTLO;
    mif.srca  = 32'hCAFE_BABE;
    @(negedge clk);
    mif.mduop = MD_MFLO;
    #1 check("mtlo_mflo", mif.mduout, 32'hCAFE_BABE);
    idle_inputs();

    // Start+MULT at busy cycle 3 is ignored; 100/7 -> q=14, r=2.
    run_op("div_ign_start", MD_DIV, 32'd100, 32'd7, 10, 3, 32'd2, 32'd14);

    // Reset at busy cycle 2 aborts the multiply; nothing commits later.
    @(negedge clk);
    mif.mduop = MD_MULT;
    mif.start = 1'b1;
    mif.srca  = 32'd7;
    mif.srcb  = 32'd9;
    @(negedge clk);
    idle_inputs();
    check("abort_busy_c1", 32'(mif.busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(mif.busy), 32'd0);
    check("abort_hi", mif.hi, 32'd0);
    check("abort_lo", mif.lo, 32'd0);
    repeat (8) @(negedge clk);
    check("abort_late_busy", 32'(mif.busy), 32'd0);
    check("abort_late_hi", mif.hi, 32'd0);
    check("abort_late_lo", mif.lo, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
